// File: rtl/signed_sub_with_overflow_pipe.sv
// Two-stage valid/ready pipeline computing a signed a - b with overflow detection,
// optional saturation, and a saturating count of delivered overflow results.
module signed_sub_with_overflow_pipe #(
    parameter int WIDTH    = 4,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             overflow,
    input  logic             ovf_clear,
    output logic [7:0]       ovf_count
);

    localparam logic [WIDTH-1:0] SIGNED_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SIGNED_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Stage 1: captured operands
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;

    // Stage 2: registered result
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             ovf_q, ovf_d;

    logic [7:0]       cnt_q, cnt_d;

    logic             s1_advance;
    logic             s2_advance;
    logic             in_hs;
    logic             out_hs;
    logic             counted_hs;

    logic [WIDTH:0]   raw;
    logic [WIDTH-1:0] wrapped;
    logic             raw_ovf;
    logic [WIDTH-1:0] result;

    // One extra bit makes overflow visible as disagreement of the top two bits.
    assign raw     = {a_q[WIDTH-1], a_q} - {b_q[WIDTH-1], b_q};
    assign wrapped = raw[WIDTH-1:0];
    assign raw_ovf = raw[WIDTH] ^ raw[WIDTH-1];

    generate
        if (SATURATE != 0) begin : g_saturate
            assign result = raw_ovf ? (a_q[WIDTH-1] ? SIGNED_MIN : SIGNED_MAX) : wrapped;
        end else begin : g_wrap
            assign result = wrapped;
        end
    endgenerate

    // Ready chain depends only on stage valids and out_ready, never on in_valid.
    assign s2_advance = !s2_valid_q || out_ready;
    assign s1_advance = !s1_valid_q || s2_advance;
    assign in_ready   = !rst && s1_advance;
    assign in_hs      = in_valid && in_ready;
    assign out_hs     = s2_valid_q && out_ready;
    assign counted_hs = out_hs && ovf_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        s2_valid_d = s2_valid_q;
        diff_d     = diff_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;

        if (s1_advance) begin
            s1_valid_d = in_hs;
            if (in_hs) begin
                a_d = a;
                b_d = b;
            end
        end

        // Result registers only change when a new pair moves in, so they hold while idle.
        if (s2_advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                diff_d = result;
                ovf_d  = raw_ovf;
            end
        end

        if (ovf_clear) begin
            cnt_d = counted_hs ? 8'd1 : 8'd0;
        end else if (counted_hs && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            s2_valid_q <= 1'b0;
            diff_q     <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= 8'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            s2_valid_q <= s2_valid_d;
            diff_q     <= diff_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign diff      = diff_q;
    assign overflow  = ovf_q;
    assign ovf_count = cnt_q;

endmodule

// File: doc/signed_sub_with_overflow_pipe.md
SIGNED_SUB_WITH_OVERFLOW_PIPE -- requirements
Module: signed_sub_with_overflow_pipe

Interface
REQ-001 Parameter WIDTH, default 4: operand and result width, two's complement; legal range 2..32.
REQ-002 Parameter SATURATE, default 0: 0 = wrapped result on overflow; 1 = clamp result to signed max/min on overflow.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  a/b operand pair presented.
REQ-006 in_ready  output  1  block accepts a pair this cycle.
REQ-007 a  input  WIDTH  signed minuend.
REQ-008 b  input  WIDTH  signed subtrahend.
REQ-009 out_valid  output  1  diff/overflow valid.
REQ-010 out_ready  input  1  downstream accepts a result this cycle.
REQ-011 diff  output  WIDTH  signed result a - b, wrapped or saturated per SATURATE.
REQ-012 overflow  output  1  true difference not representable in WIDTH bits.
REQ-013 ovf_clear  input  1  clear overflow event counter.
REQ-014 ovf_count  output  8  count of delivered results with overflow = 1, saturating.

Function
REQ-015 Input handshake occurs when in_valid && in_ready; output handshake occurs when out_valid && out_ready.
REQ-016 Two register stages: S1 captures a, b and valid; S2 holds diff, overflow and valid; out_valid is S2 valid.
REQ-017 Stage Sn advances when it is empty or its downstream consumes this cycle; S2 is consumed by an output handshake.
REQ-018 in_ready = S1 empty, or S1 advancing this cycle; in_ready is combinational from out_ready and stage valids only, never from in_valid.
REQ-019 Latency: accepted pair appears at out_valid 2 cycles after the input handshake when no stall occurs.
REQ-020 Throughput: 1 result per cycle while out_ready = 1 continuously.
REQ-021 Stall: while out_valid && !out_ready, diff and overflow hold stable and no data is lost or duplicated; at most 2 pairs in flight.
REQ-022 Raw result: raw = a - b computed in WIDTH+1 bits with sign extension; wrapped diff = raw[WIDTH-1:0].
REQ-023 Overflow = (a[MSB] != b[MSB]) && (wrapped diff[MSB] != a[MSB]); equivalently raw[WIDTH] != raw[WIDTH-1].
REQ-024 SATURATE=1 with overflow: a non-negative gives diff = 2^(WIDTH-1)-1; a negative gives diff = -2^(WIDTH-1); the overflow flag is still 1.
REQ-025 b = most-negative value: 0 - min overflows; -1 - min = max does not overflow.
REQ-026 ovf_count increments by 1 on each output handshake with overflow = 1; holds at 255 and does not wrap.
REQ-027 ovf_clear with no simultaneous counted handshake gives ovf_count = 0 next cycle; ovf_clear with a simultaneous counted handshake gives ovf_count = 1.
REQ-028 When out_valid = 0, diff and overflow hold their last values; the bench does not check them.

Reset
REQ-029 rst high at a rising edge: S1 and S2 valid = 0, out_valid = 0, diff = 0, overflow = 0, ovf_count = 0.
REQ-030 Reset mid-operation discards all in-flight pairs; no result is delivered for pairs accepted before reset.
REQ-031 in_ready = 0 while rst = 1; in_ready = 1 the first cycle after rst is deasserted.

Verification (WIDTH=4)
REQ-032 SATURATE=0, out_ready=1: a=5, b=3 -> 2 cycles later diff=2, overflow=0; a=-3, b=5 -> diff=-8, overflow=0.
REQ-033 SATURATE=0: a=3, b=-5 -> diff=-8 (4'b1000), overflow=1; a=-8, b=1 -> diff=7, overflow=1; a=0, b=-8 -> diff=-8, overflow=1; a=-1, b=-8 -> diff=7, overflow=0.
REQ-034 SATURATE=1: a=3, b=-5 -> diff=7, overflow=1; a=-8, b=1 -> diff=-8, overflow=1; a=4, b=2 -> diff=2, overflow=0.
REQ-035 Backpressure: stream 6 pairs with in_valid=1 while out_ready is held 0 for 4 cycles -> in_ready drops after 2 accepts, the held result stays stable, and all 6 results arrive in order with no gaps or duplicates once out_ready=1.
REQ-036 Counter: deliver 260 overflowing results -> ovf_count=255; ovf_clear together with an overflowing handshake -> ovf_count=1; ovf_clear alone -> ovf_count=0.
REQ-037 Reset mid-stream: assert rst one cycle after 2 accepts -> out_valid stays 0, ovf_count=0, and the first post-reset pair arrives 2 cycles after its accept.
